// File: rtl/gpu_local_responder_if.sv
// Host/GPU/RAM/register-window bundle for gpu_local_responder.
// The slave modport is the responder; the master modport is the host CPU side plus the memories.
interface gpu_local_responder_if;
    logic        ioreq;
    logic        io_wr;
    logic [12:0] cpuaddr;
    logic [31:0] cpudata;
    logic        ack;
    logic [31:0] mem_data;
    logic        gpu_req;
    logic        gpu_gnt;
    logic        ram_cs;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        reg_cs;
    logic        reg_we;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport slave (
        input  ioreq, io_wr, cpuaddr, cpudata, gpu_req, ram_rdata, reg_rdata,
        output ack, mem_data, gpu_gnt,
               ram_cs, ram_we, ram_addr, ram_wdata,
               reg_cs, reg_we, reg_addr, reg_wdata
    );

    modport master (
        output ioreq, io_wr, cpuaddr, cpudata, gpu_req, ram_rdata, reg_rdata,
        input  ack, mem_data, gpu_gnt,
               ram_cs, ram_we, ram_addr, ram_wdata,
               reg_cs, reg_we, reg_addr, reg_wdata
    );
endinterface

// File: rtl/gpu_local_responder.sv
// Host I/O responder: arbitrates one host access against GPU local-RAM traffic.
// Optional one-entry write-post buffer enabled by `define GPU_IOREQ_WRPOST_EN.
module gpu_local_responder #(
    parameter int STARVE_MAX = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    gpu_local_responder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARB, ACCESS, DATA, DONE} state_t;

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] data;
    } req_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state;
    req_t       req;
    logic [2:0] starve_cnt;
    logic       host_wins;

`ifdef GPU_IOREQ_WRPOST_EN
    // Latched write already acknowledged; the FSM stays busy until it drains.
    logic       posted;
`endif

    assign host_wins   = !bus.gpu_req || (starve_cnt == STARVE_LIM);
    assign bus.gpu_gnt = bus.gpu_req & (state != ACCESS);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req           <= '0;
            starve_cnt    <= '0;
            bus.ack       <= 1'b0;
            bus.mem_data  <= '0;
            bus.ram_cs    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.reg_cs    <= 1'b0;
            bus.reg_we    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
`ifdef GPU_IOREQ_WRPOST_EN
            posted        <= 1'b0;
`endif
        end else begin
            bus.ack    <= 1'b0;
            bus.ram_cs <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.reg_cs <= 1'b0;
            bus.reg_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ioreq) begin
                        req        <= '{wr: bus.io_wr, addr: bus.cpuaddr, data: bus.cpudata};
                        starve_cnt <= '0;
                        state      <= ARB;
`ifdef GPU_IOREQ_WRPOST_EN
                        posted     <= bus.io_wr;
                        bus.ack    <= bus.io_wr;
`endif
                    end
                end
                ARB: begin
                    if (host_wins) begin
                        // Strobes are registered, so they are set on entry to ACCESS.
                        state <= ACCESS;
                        if (req.addr[12]) begin
                            bus.ram_cs    <= 1'b1;
                            bus.ram_we    <= req.wr;
                            bus.ram_addr  <= req.addr[11:0];
                            bus.ram_wdata <= req.data;
                        end else begin
                            bus.reg_cs    <= 1'b1;
                            bus.reg_we    <= req.wr;
                            bus.reg_addr  <= req.addr[11:0];
                            bus.reg_wdata <= req.data;
                        end
                    end else if (starve_cnt != 3'd7) begin
                        starve_cnt <= starve_cnt + 3'd1;
                    end
                end
                ACCESS: begin
                    state <= req.wr ? DONE : DATA;
`ifdef GPU_IOREQ_WRPOST_EN
                    bus.ack <= req.wr & ~posted;
`else
                    bus.ack <= req.wr;
`endif
                end
                DATA: begin
                    bus.mem_data <= req.addr[12] ? bus.ram_rdata : bus.reg_rdata;
                    bus.ack      <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    state <= IDLE;
`ifdef GPU_IOREQ_WRPOST_EN
                    posted <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_local_responder.sv
// Scoreboard bench for gpu_local_responder: stimulus pushes expected acks/strobes,
// negedge monitors pop and compare.
module tb_gpu_local_responder;
`ifdef GPU_IOREQ_WRPOST_EN
    localparam int WR_ACK    = 1;
    localparam int RAW_EXTRA = 2;
`else
    localparam int WR_ACK    = 3;
    localparam int RAW_EXTRA = 0;
`endif

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] data;
    } ack_exp_t;

    typedef struct {
        int          cyc;
        bit          ram;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } stb_exp_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    ack_exp_t ack_q[$];
    stb_exp_t stb_q[$];
    ack_exp_t ae;
    stb_exp_t se;

    logic [31:0] ram_mem [0:4095];
    logic [31:0] reg_mem [0:4095];
    logic [4095:0] ram_vld, reg_vld;

    gpu_local_responder_if bus();

    gpu_local_responder #(.STARVE_MAX(4)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Memories: unwritten RAM words read as DEADBEEB^addr (so 0x004 -> DEADBEEF).
    always @(posedge sys_clk) begin
        if (reset) begin
            ram_vld <= '0;
            reg_vld <= '0;
        end else begin
            if (bus.ram_cs) begin
                if (bus.ram_we) begin
                    ram_mem[bus.ram_addr] <= bus.ram_wdata;
                    ram_vld[bus.ram_addr] <= 1'b1;
                end
                bus.ram_rdata <= ram_vld[bus.ram_addr] ? ram_mem[bus.ram_addr]
                                                       : (32'hDEADBEEB ^ {20'h0, bus.ram_addr});
            end
            if (bus.reg_cs) begin
                if (bus.reg_we) begin
                    reg_mem[bus.reg_addr] <= bus.reg_wdata;
                    reg_vld[bus.reg_addr] <= 1'b1;
                end
                bus.reg_rdata <= reg_vld[bus.reg_addr] ? reg_mem[bus.reg_addr]
                                                       : (32'h5EC00000 | {20'h0, bus.reg_addr});
            end
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge sys_clk) begin
        if (bus.ack === 1'b1) begin
            if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
            else begin
                ae = ack_q.pop_front();
                chk("ack_cycle", cyc, ae.cyc);
                if (ae.rd) chk("mem_data", bus.mem_data, ae.data);
            end
        end
        if (bus.ram_cs === 1'b1 || bus.reg_cs === 1'b1) begin
            if (stb_q.size() == 0) chk("strobe_unexpected", 1, 0);
            else begin
                se = stb_q.pop_front();
                chk("strobe_cycle", cyc, se.cyc);
                chk("strobe_sel", {bus.ram_cs, bus.reg_cs}, se.ram ? 2'b10 : 2'b01);
                if (se.ram) chk("ram_bus", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {se.we, se.addr, se.wdata});
                else        chk("reg_bus", {bus.reg_we, bus.reg_addr, bus.reg_wdata}, {se.we, se.addr, se.wdata});
            end
        end
    end

    task automatic issue(input bit wr, input logic [12:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input int ack_lat, input int stb_lat,
                         input int extra, output int c);
        @(negedge sys_clk);
        c           = cyc;
        bus.ioreq   = 1'b1;
        bus.io_wr   = wr;
        bus.cpuaddr = a;
        bus.cpudata = d;
        ack_q.push_back('{c + extra + ack_lat, !wr, exp_rd});
        stb_q.push_back('{c + extra + stb_lat, a[12], wr, a[11:0], d});
    endtask

    task automatic wait_ack(input int n);
        int seen = 0;
        for (int i = 0; i < 64 && seen < n; i++) begin
            @(negedge sys_clk);
            if (bus.ack === 1'b1) seen++;
        end
        if (seen < n) chk("ack_timeout", seen, n);
        bus.ioreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.ioreq = 0; bus.io_wr = 0; bus.cpuaddr = '0; bus.cpudata = '0; bus.gpu_req = 0;
        repeat (3) @(negedge sys_clk);
        chk("rst_ctrl", {bus.ack, bus.ram_cs, bus.reg_cs, bus.ram_we, bus.reg_we, bus.gpu_gnt}, 6'b0);
        chk("rst_addr", {bus.ram_addr, bus.reg_addr}, 24'h0);
        chk("rst_wdata", {bus.ram_wdata, bus.reg_wdata}, 64'h0);
        chk("rst_mem_data", bus.mem_data, 32'h0);
        reset = 1'b0;

        // Uncontended RAM read.
        issue(1'b0, 13'h1004, 32'h0, 32'hDEADBEEF, 4, 2, 0, c);
        wait_ack(1);
        repeat (4) @(negedge sys_clk);

        // Register write, then read it back.
        issue(1'b1, 13'h0010, 32'h12345678, 32'h0, WR_ACK, 2, 0, c);
        wait_ack(1);
        repeat (4) @(negedge sys_clk);
        issue(1'b0, 13'h0010, 32'h0, 32'h12345678, 4, 2, 0, c);
        wait_ack(1);
        repeat (2) @(negedge sys_clk);

        // GPU holds the port: four lost ARB cycles then a forced slot.
        bus.gpu_req = 1'b1;
        issue(1'b0, 13'h1004, 32'h0, 32'hDEADBEEF, 8, 6, 0, c);
        for (int n = 1; n <= 8; n++) begin
            @(negedge sys_clk);
            chk("gpu_gnt", bus.gpu_gnt, (cyc == c + 6) ? 1'b0 : 1'b1);
        end
        bus.ioreq   = 1'b0;
        bus.gpu_req = 1'b0;
        repeat (2) @(negedge sys_clk);

        // GPU releases after two lost ARB cycles.
        bus.gpu_req = 1'b1;
        issue(1'b0, 13'h0020, 32'h0, 32'h5EC00020, 6, 4, 0, c);
        repeat (3) @(negedge sys_clk);
        bus.gpu_req = 1'b0;
        wait_ack(1);
        repeat (2) @(negedge sys_clk);

        // ioreq held across ack: second transaction starts after DONE.
        issue(1'b0, 13'h1004, 32'h0, 32'hDEADBEEF, 4, 2, 0, c);
        ack_q.push_back('{c + 9, 1'b1, 32'hDEADBEEF});
        stb_q.push_back('{c + 7, 1'b1, 1'b0, 12'h004, 32'h0});
        wait_ack(2);
        repeat (6) @(negedge sys_clk);

        // Reset during ACCESS abandons the read.
        issue(1'b0, 13'h1004, 32'h0, 32'hDEADBEEF, 4, 2, 0, c);
        repeat (2) @(negedge sys_clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {bus.ack, bus.ram_cs, bus.reg_cs, bus.ram_we, bus.reg_we}, 5'b0);
        chk("rst_mid_mem_data", bus.mem_data, 32'h0);
        ack_q.delete();
        bus.ioreq = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("rst_mid_edge", {bus.ack, bus.ram_cs, bus.reg_cs}, 3'b0);
        @(negedge sys_clk);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Write then immediate read of the same RAM word.
        issue(1'b1, 13'h1020, 32'hA5A5A5A5, 32'h0, WR_ACK, 2, 0, c);
        wait_ack(1);
        issue(1'b0, 13'h1020, 32'h0, 32'hA5A5A5A5, 4, 2, RAW_EXTRA, c);
        wait_ack(1);
        repeat (6) @(negedge sys_clk);

        chk("ack_q_drained", ack_q.size(), 0);
        chk("stb_q_drained", stb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
